// File: rtl/data_to_axi_pkg.sv
// Shared helpers for the element-to-AXI4S packer.
package data_to_axi_pkg;

   // Width of a counter indexing n slots; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/data_to_axi.sv
// Packs a single-element stream into AXI4S beats of NUM_ELEMENTS slots each;
// a beat is emitted when full or when an element carries last.
module data_to_axi
   import data_to_axi_pkg::*;
#(
   parameter type         data_t       = logic [31:0],
   parameter int unsigned AXI_WIDTH    = 512,
   parameter int unsigned DATA_WIDTH   = $bits(data_t),
   parameter int unsigned NUM_ELEMENTS = AXI_WIDTH / DATA_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  data_t                  in_data_i,
   input  logic                   in_keep_i,
   input  logic                   in_last_i,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   output logic [AXI_WIDTH-1:0]   out_tdata_o,
   output logic [AXI_WIDTH/8-1:0] out_tkeep_o,
   output logic                   out_tlast_o,
   output logic                   out_tvalid_o,
   input  logic                   out_tready_i
);

   localparam int unsigned KW = DATA_WIDTH / 8;
   localparam int unsigned BW = AXI_WIDTH / 8;

   if (NUM_ELEMENTS * DATA_WIDTH != AXI_WIDTH) begin : g_chk_width
      $error("data_to_axi: NUM_ELEMENTS * DATA_WIDTH must equal AXI_WIDTH");
   end
   if (DATA_WIDTH % 8 != 0 || DATA_WIDTH != $bits(data_t)) begin : g_chk_data
      $error("data_to_axi: DATA_WIDTH must equal $bits(data_t) and be a multiple of 8");
   end
   if (NUM_ELEMENTS == 0 || (NUM_ELEMENTS & (NUM_ELEMENTS - 1)) != 0) begin : g_chk_pow2
      $error("data_to_axi: NUM_ELEMENTS must be a power of two");
   end

   logic [DATA_WIDTH-1:0] in_bits;
   logic                  accept;
   logic                  complete;
   logic [AXI_WIDTH-1:0]  beat_data;
   logic [BW-1:0]         beat_keep;

   logic [AXI_WIDTH-1:0]  o_data_q, o_data_d;
   logic [BW-1:0]         o_keep_q, o_keep_d;
   logic                  o_last_q, o_last_d;
   logic                  o_valid_q, o_valid_d;

   assign in_bits    = in_data_i;
   assign in_ready_o = !o_valid_q || out_tready_i;
   assign accept     = in_valid_i && in_ready_o;

   if (NUM_ELEMENTS == 1) begin : g_single
      assign complete  = 1'b1;
      assign beat_data = in_bits;
      assign beat_keep = {KW{in_keep_i}};
   end else begin : g_pack
      localparam int unsigned    SW        = cnt_width(NUM_ELEMENTS);
      localparam logic [SW-1:0]  LAST_SLOT = SW'(NUM_ELEMENTS - 1);

      logic [SW-1:0]                            slot_q, slot_d;
      logic [NUM_ELEMENTS-2:0][DATA_WIDTH-1:0]  acc_data_q, acc_data_d;
      logic [NUM_ELEMENTS-2:0]                  acc_keep_q, acc_keep_d;
      logic [AXI_WIDTH-1:0]                     acc_flat;
      logic [NUM_ELEMENTS-1:0]                  keep_flat;

      assign complete  = (slot_q == LAST_SLOT) || in_last_i;
      assign acc_flat  = {{DATA_WIDTH{1'b0}}, acc_data_q};
      assign keep_flat = {1'b0, acc_keep_q};

      // Stale accumulator data above the current slot must not leak into a short beat.
      always_comb begin
         beat_data = '0;
         beat_keep = '0;
         for (int unsigned i = 0; i < NUM_ELEMENTS; i++) begin
            if (i < 32'(slot_q)) begin
               beat_data[i*DATA_WIDTH +: DATA_WIDTH] = acc_flat[i*DATA_WIDTH +: DATA_WIDTH];
               beat_keep[i*KW +: KW]                 = {KW{keep_flat[i]}};
            end else if (i == 32'(slot_q)) begin
               beat_data[i*DATA_WIDTH +: DATA_WIDTH] = in_bits;
               beat_keep[i*KW +: KW]                 = {KW{in_keep_i}};
            end
         end
      end

      always_comb begin
         slot_d     = slot_q;
         acc_data_d = acc_data_q;
         acc_keep_d = acc_keep_q;
         if (accept) begin
            if (complete) begin
               slot_d     = '0;
               acc_keep_d = '0;
            end else begin
               acc_data_d[slot_q] = in_bits;
               acc_keep_d[slot_q] = in_keep_i;
               slot_d             = slot_q + 1'b1;
            end
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            slot_q     <= '0;
            acc_data_q <= '0;
            acc_keep_q <= '0;
         end else begin
            slot_q     <= slot_d;
            acc_data_q <= acc_data_d;
            acc_keep_q <= acc_keep_d;
         end
      end
   end

   // A reload in the same cycle as a drain keeps O valid.
   always_comb begin
      o_data_d  = o_data_q;
      o_keep_d  = o_keep_q;
      o_last_d  = o_last_q;
      o_valid_d = o_valid_q && !out_tready_i;
      if (accept && complete) begin
         o_data_d  = beat_data;
         o_keep_d  = beat_keep;
         o_last_d  = in_last_i;
         o_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_data_q  <= '0;
         o_keep_q  <= '0;
         o_last_q  <= 1'b0;
         o_valid_q <= 1'b0;
      end else begin
         o_data_q  <= o_data_d;
         o_keep_q  <= o_keep_d;
         o_last_q  <= o_last_d;
         o_valid_q <= o_valid_d;
      end
   end

   assign out_tdata_o  = o_data_q;
   assign out_tkeep_o  = o_keep_q;
   assign out_tlast_o  = o_last_q;
   assign out_tvalid_o = o_valid_q;

endmodule

// File: tb/tb_data_to_axi.sv
// Bench for data_to_axi: 32-bit elements into 128-bit beats, plus a 1-slot instance.
module tb_data_to_axi;

   typedef struct packed {
      logic [127:0] data;
      logic [15:0]  keep;
      logic         last;
   } beat_t;

   typedef struct {
      int           n;
      logic [31:0]  d [4];
      logic [3:0]   k;
      logic         last;
      logic [127:0] ed;
      logic [15:0]  ek;
      logic         el;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [31:0]  in_data = '0;
   logic         in_keep = 1'b0;
   logic         in_last = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] out_tdata;
   logic [15:0]  out_tkeep;
   logic         out_tlast;
   logic         out_tvalid;
   logic         out_tready = 1'b0;

   logic [31:0]  n1_data = '0;
   logic         n1_keep = 1'b0;
   logic         n1_last = 1'b0;
   logic         n1_valid = 1'b0;
   logic         n1_ready;
   logic [31:0]  n1_tdata;
   logic [3:0]   n1_tkeep;
   logic         n1_tlast;
   logic         n1_tvalid;
   logic         n1_tready = 1'b0;

   always #5 clk = ~clk;

   data_to_axi #(.data_t(logic [31:0]), .AXI_WIDTH(128)) dut (
      .clk(clk), .rst(rst),
      .in_data_i(in_data), .in_keep_i(in_keep), .in_last_i(in_last),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .out_tdata_o(out_tdata), .out_tkeep_o(out_tkeep), .out_tlast_o(out_tlast),
      .out_tvalid_o(out_tvalid), .out_tready_i(out_tready)
   );

   data_to_axi #(.data_t(logic [31:0]), .AXI_WIDTH(32)) dut1 (
      .clk(clk), .rst(rst),
      .in_data_i(n1_data), .in_keep_i(n1_keep), .in_last_i(n1_last),
      .in_valid_i(n1_valid), .in_ready_o(n1_ready),
      .out_tdata_o(n1_tdata), .out_tkeep_o(n1_tkeep), .out_tlast_o(n1_tlast),
      .out_tvalid_o(n1_tvalid), .out_tready_i(n1_tready)
   );

   int    checks = 0;
   int    failures = 0;
   int    beats_seen = 0;
   int    stall_cycles = 0;
   int    send_cycles = 0;
   bit    use_model = 1'b0;
   beat_t exp_q [$];

   logic [127:0] m_data = '0;
   logic [15:0]  m_keep = '0;
   int           m_slot = 0;

   function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endfunction

   function automatic void model_reset();
      m_data = '0;
      m_keep = '0;
      m_slot = 0;
   endfunction

   function automatic void model_accept(input logic [31:0] d, input logic k, input logic l);
      m_data[m_slot*32 +: 32] = d;
      m_keep[m_slot*4 +: 4]   = {4{k}};
      if (m_slot == 3 || l) begin
         exp_q.push_back('{data: m_data, keep: m_keep, last: l});
         model_reset();
      end else begin
         m_slot++;
      end
   endfunction

   // Holds the element on the bus until a rising edge sees it accepted.
   task automatic send(input logic [31:0] d, input logic k, input logic l);
      bit ok;
      bit r;
      ok       = 1'b0;
      in_data  = d;
      in_keep  = k;
      in_last  = l;
      in_valid = 1'b1;
      for (int g = 0; g < 50; g++) begin
         @(negedge clk);
         r = in_ready;
         @(posedge clk);
         #1;
         send_cycles++;
         if (r) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("send_timeout", 1, 0);
      else if (use_model) model_accept(d, k, l);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   beat_t prev_beat;
   bit    prev_stall = 1'b0;

   always @(negedge clk) begin
      beat_t e;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_tvalid", out_tvalid, 1);
            chk("hold_tdata", out_tdata, prev_beat.data);
            chk("hold_tkeep", out_tkeep, prev_beat.keep);
            chk("hold_tlast", out_tlast, prev_beat.last);
         end
         if (out_tvalid && !out_tready) begin
            stall_cycles++;
            chk("stall_in_ready", in_ready, 0);
         end
         if (!out_tvalid) chk("idle_in_ready", in_ready, 1);
         if (out_tvalid && out_tready) begin
            beats_seen++;
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("beat_tdata", out_tdata, e.data);
               chk("beat_tkeep", out_tkeep, e.keep);
               chk("beat_tlast", out_tlast, e.last);
            end
         end
         prev_stall     = out_tvalid && !out_tready;
         prev_beat.data = out_tdata;
         prev_beat.keep = out_tkeep;
         prev_beat.last = out_tlast;
      end
   end

   vec_t vecs [5];

   initial begin
      int b0;
      logic [31:0] n1_d;
      logic        n1_k;

      vecs[0].n = 4; vecs[0].d = '{32'h1, 32'h2, 32'h3, 32'h4}; vecs[0].k = 4'b1111;
      vecs[0].last = 1'b1; vecs[0].ed = 128'h00000004_00000003_00000002_00000001;
      vecs[0].ek = 16'hFFFF; vecs[0].el = 1'b1;
      vecs[1].n = 2; vecs[1].d = '{32'hA, 32'hB, 32'h0, 32'h0}; vecs[1].k = 4'b0011;
      vecs[1].last = 1'b1; vecs[1].ed = 128'h0000000B_0000000A;
      vecs[1].ek = 16'h00FF; vecs[1].el = 1'b1;
      vecs[2].n = 4; vecs[2].d = '{32'h11, 32'h22, 32'h33, 32'h44}; vecs[2].k = 4'b1101;
      vecs[2].last = 1'b1; vecs[2].ed = 128'h00000044_00000033_00000022_00000011;
      vecs[2].ek = 16'hFF0F; vecs[2].el = 1'b1;
      vecs[3].n = 1; vecs[3].d = '{32'h55, 32'h0, 32'h0, 32'h0}; vecs[3].k = 4'b0000;
      vecs[3].last = 1'b1; vecs[3].ed = 128'h55;
      vecs[3].ek = 16'h0000; vecs[3].el = 1'b1;
      vecs[4].n = 4; vecs[4].d = '{32'h5, 32'h6, 32'h7, 32'h8}; vecs[4].k = 4'b1111;
      vecs[4].last = 1'b0; vecs[4].ed = 128'h00000008_00000007_00000006_00000005;
      vecs[4].ek = 16'hFFFF; vecs[4].el = 1'b0;

      #2;
      chk("reset_tvalid", out_tvalid, 0);
      chk("reset_tdata", out_tdata, 0);
      chk("reset_tkeep", out_tkeep, 0);
      chk("reset_tlast", out_tlast, 0);
      chk("reset_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      rst        = 1'b0;
      out_tready = 1'b1;
      n1_tready  = 1'b1;
      idle(1);

      // Table vectors with constant expectations
      use_model = 1'b0;
      foreach (vecs[v]) begin
         exp_q.push_back('{data: vecs[v].ed, keep: vecs[v].ek, last: vecs[v].el});
         for (int j = 0; j < vecs[v].n; j++) begin
            send(vecs[v].d[j], vecs[v].k[j], vecs[v].last && (j == vecs[v].n - 1));
            if (j == vecs[v].n - 2) chk("pre_last_tvalid", out_tvalid, 0);
         end
         chk("latency_tvalid", out_tvalid, 1);
         idle(2);
      end

      // Backpressure: 8 elements, downstream stalls 5 cycles after the first beat
      use_model    = 1'b1;
      model_reset();
      stall_cycles = 0;
      b0           = beats_seen;
      fork
         begin
            for (int i = 0; i < 8; i++) send(32'h100 + 32'(i), 1'($urandom_range(0, 1)), 1'b0);
            idle(1);
         end
         begin
            for (int c = 0; c < 100; c++) begin
               @(posedge clk);
               #1;
               if (out_tvalid) break;
            end
            out_tready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            out_tready = 1'b1;
         end
      join
      idle(3);
      chk("bp_stall_cycles", stall_cycles, 5);
      chk("bp_beats", beats_seen - b0, 2);

      // Continuous stream at full rate
      send_cycles = 0;
      b0          = beats_seen;
      for (int i = 0; i < 12; i++) send(32'h200 + 32'(i), 1'b1, i == 11);
      chk("throughput_cycles", send_cycles, 12);
      idle(2);
      chk("throughput_beats", beats_seen - b0, 3);

      // Reset while a beat is stalled in O
      for (int i = 0; i < 4; i++) send(32'h300 + 32'(i), 1'b1, 1'b0);
      out_tready = 1'b0;
      in_valid   = 1'b0;
      #2;
      rst = 1'b1;
      exp_q.delete();
      model_reset();
      #1;
      chk("rstA_tvalid", out_tvalid, 0);
      chk("rstA_tdata", out_tdata, 0);
      chk("rstA_tkeep", out_tkeep, 0);
      chk("rstA_tlast", out_tlast, 0);
      @(posedge clk);
      #1;
      rst        = 1'b0;
      out_tready = 1'b1;
      idle(1);

      // Reset mid-packet, then a clean beat from slot 0
      send(32'hDEAD0001, 1'b1, 1'b0);
      send(32'hDEAD0002, 1'b1, 1'b0);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      exp_q.delete();
      model_reset();
      #1;
      chk("rstB_tvalid", out_tvalid, 0);
      chk("rstB_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(1);
      b0 = beats_seen;
      for (int i = 0; i < 4; i++) send(32'h400 + 32'(i), 1'b1, i == 3);
      idle(2);
      chk("rstB_beats", beats_seen - b0, 1);

      // Single-slot instance: every element is a beat, O stays valid back to back
      n1_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         n1_d    = $urandom;
         n1_k    = (i % 3) != 0;
         n1_data = n1_d;
         n1_keep = n1_k;
         n1_last = (i == 5);
         @(negedge clk);
         chk("n1_in_ready", n1_ready, 1);
         @(posedge clk);
         #1;
         chk("n1_tvalid", n1_tvalid, 1);
         chk("n1_tdata", n1_tdata, n1_d);
         chk("n1_tkeep", n1_tkeep, n1_k ? 4'hF : 4'h0);
         chk("n1_tlast", n1_tlast, i == 5);
      end
      n1_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("n1_drained", n1_tvalid, 0);

      for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clk);
      #1;
      chk("queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
